// File: rtl/arb_pkg.sv
// Shared encodings and sizing helpers for the arbitrating multiplexer.
package arb_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Channel-index width; a two-channel build still needs one bit.
    function automatic int calc_cw(input int channels);
        return (channels > 2) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant selection over the requesting channels, with the rotating priority pointer.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int MODE     = MODE_RR
)(
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           req,
    input  logic                          load_en,
    output logic [CHANNELS-1:0]           grant,
    output logic [calc_cw(CHANNELS)-1:0]  grant_idx
);

    localparam int CW = calc_cw(CHANNELS);

    logic [CW-1:0] ptr_q;
    logic [CW-1:0] ptr_d;
    logic [CW:0]   slot;

    // Walk the search order backwards so the earliest requester after ptr_q wins the last write.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        slot      = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            slot = {1'b0, ptr_q} + (CW + 1)'(k);
            if (slot >= (CW + 1)'(CHANNELS)) begin
                slot = slot - (CW + 1)'(CHANNELS);
            end
            if (req[slot[CW-1:0]]) begin
                grant                 = '0;
                grant[slot[CW-1:0]]   = 1'b1;
                grant_idx             = slot[CW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (MODE == MODE_RR && load_en && (|grant)) begin
            ptr_d = (grant_idx == CW'(CHANNELS - 1)) ? '0 : grant_idx + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrating multiplexer: one grant per cycle into a single registered output stage.
module arb_mux
    import arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int MODE     = MODE_RR
)(
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CHANNELS*WIDTH-1:0]     in_data,
    input  logic [CHANNELS-1:0]           in_valid,
    output logic [CHANNELS-1:0]           in_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [calc_cw(CHANNELS)-1:0]  out_channel
);

    localparam int CW = calc_cw(CHANNELS);

    logic                load_en;
    logic                transfer;
    logic [CHANNELS-1:0] grant;
    logic [CW-1:0]       grant_idx;
    logic [WIDTH-1:0]    sel_data;

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [CW-1:0]       out_channel_q, out_channel_d;

    // Handshake: channel i transfers when in_valid[i] & in_ready[i]; the output drains on out_valid & out_ready.
    assign load_en  = (!out_valid_q || out_ready) && !reset;
    assign in_ready = grant & {CHANNELS{load_en}};
    assign transfer = |in_ready;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .MODE     (MODE)
    ) u_arbiter (
        .clock     (clock),
        .reset     (reset),
        .req       (in_valid),
        .load_en   (load_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        if (transfer) begin
            out_valid_d   = 1'b1;
            out_data_d    = sel_data;
            out_channel_d = grant_idx;
        end else if (out_ready) begin
            out_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Randomised bench for arb_mux: round-robin and fixed-priority instances against a behavioural model.
module tb_arb_mux;

    localparam int W = 32;
    localparam int N = 4;

    logic           clock;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_channel;

    logic           f_reset;
    logic [N*W-1:0] f_in_data;
    logic [N-1:0]   f_in_valid;
    logic [N-1:0]   f_in_ready;
    logic [W-1:0]   f_out_data;
    logic           f_out_valid;
    logic           f_out_ready;
    logic [1:0]     f_out_channel;

    int checks = 0;
    int errors = 0;
    int deliveries = 0;
    int m_ptr = 0;
    logic [W+1:0] exp_q[$];   // {channel, data} of the word expected in the output register
    logic [W+1:0] head;

    arb_mux #(.WIDTH(W), .CHANNELS(N), .MODE(0)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_channel(out_channel)
    );

    arb_mux #(.WIDTH(W), .CHANNELS(N), .MODE(1)) dut_fixed (
        .clock(clock), .reset(f_reset), .in_data(f_in_data), .in_valid(f_in_valid),
        .in_ready(f_in_ready), .out_data(f_out_data), .out_valid(f_out_valid),
        .out_ready(f_out_ready), .out_channel(f_out_channel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [W-1:0] chunk_of(input logic [N*W-1:0] d, input int c);
        return W'(d >> (W * c));
    endfunction

    // Round-robin expectation: first valid channel searching from the pointer, when the stage can load.
    function automatic logic [N-1:0] exp_ready();
        if (reset || (exp_q.size() != 0 && !out_ready)) return '0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) return N'(1 << c);
        end
        return '0;
    endfunction

    task automatic tick();
        logic [N-1:0] g;
        g = exp_ready();
        if (out_valid === 1'b1 && out_ready && !reset) deliveries++;
        @(posedge clock);
        if (reset) begin
            exp_q.delete();
            m_ptr = 0;
        end else begin
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            for (int c = 0; c < N; c++) begin
                if (g[c]) begin
                    exp_q.push_back({2'(c), chunk_of(in_data, c)});
                    m_ptr = (c + 1) % N;
                end
            end
        end
        #1;
    endtask

    task automatic rand_data();
        in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            reset = 1'b1; in_valid = 4'hF; out_ready = 1'b1; rand_data();
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++; $display("FAIL reset_ready got %b want 0000", in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_data !== '0 || out_channel !== 2'd0) begin
                errors++; $display("FAIL reset_state got v=%b d=%h c=%0d want 0/0/0", out_valid, out_data, out_channel);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 9; i++) begin
            in_valid = (i < 8) ? 4'hF : 4'h0; out_ready = 1'b1; rand_data();
            #1;
            checks++;
            if (in_ready !== exp_ready() || !$onehot0(in_ready)) begin
                errors++; $display("FAIL rr_ready got %b want %b", in_ready, exp_ready());
            end
            tick();
            checks++;
            if (out_valid !== (exp_q.size() != 0)) begin
                errors++; $display("FAIL rr_valid got %b want %b", out_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                checks++;
                if ({out_channel, out_data} !== head) begin
                    errors++; $display("FAIL rr_data got %0d/%h want %0d/%h", out_channel, out_data, head[W+1:W], head[W-1:0]);
                end
            end
            if (i < 8) begin
                checks++;
                if (out_channel !== 2'(i % N)) begin
                    errors++; $display("FAIL rr_sequence got %0d want %0d", out_channel, i % N);
                end
            end
        end
    endtask

    task automatic test_stall();
        deliveries = 0;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            case (i)
                0:       begin in_valid = 4'b0100; out_ready = 1'b1; in_data[95:64] = 32'hDEADBEEF; end
                1, 2, 3: begin in_valid = 4'($urandom_range(0, 15)); out_ready = 1'b0; end
                default: begin in_valid = 4'b0000; out_ready = 1'b1; end
            endcase
            #1;
            checks++;
            if (in_ready !== exp_ready() || !$onehot0(in_ready)) begin
                errors++; $display("FAIL stall_ready got %b want %b", in_ready, exp_ready());
            end
            if (i >= 1 && i <= 3) begin
                checks++;
                if (in_ready !== 4'b0000) begin
                    errors++; $display("FAIL stall_blocked got %b want 0000", in_ready);
                end
            end
            tick();
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                checks++;
                if ({out_channel, out_data} !== head) begin
                    errors++; $display("FAIL stall_data got %0d/%h want %0d/%h", out_channel, out_data, head[W+1:W], head[W-1:0]);
                end
            end
            if (i <= 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_channel !== 2'd2) begin
                    errors++; $display("FAIL stall_hold got v=%b d=%h c=%0d want 1/deadbeef/2", out_valid, out_data, out_channel);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL stall_release got %b want 0", out_valid);
                end
            end
        end
        checks++;
        if (deliveries != 1) begin
            errors++; $display("FAIL stall_deliveries got %0d want 1", deliveries);
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] want_rdy [6];
        want_rdy = '{4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 2) ? 4'b1001 : 4'b0001; out_ready = 1'b1; rand_data();
            #1;
            checks++;
            if (in_ready !== want_rdy[i] || in_ready !== exp_ready()) begin
                errors++; $display("FAIL wrap_grant got %b want %b", in_ready, want_rdy[i]);
            end
            tick();
            checks++;
            head = exp_q[0];
            if (out_valid !== 1'b1 || {out_channel, out_data} !== head) begin
                errors++; $display("FAIL wrap_data got %b/%0d/%h want 1/%0d/%h", out_valid, out_channel, out_data, head[W+1:W], head[W-1:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            rand_data();
            case (i)
                0:       begin reset = 1'b0; in_valid = 4'b0010; out_ready = 1'b1; end
                1:       begin reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b0; end
                default: begin reset = 1'b0; in_valid = 4'b1111; out_ready = 1'b1; end
            endcase
            #1;
            checks++;
            if (in_ready !== exp_ready() || !$onehot0(in_ready)) begin
                errors++; $display("FAIL rmid_ready got %b want %b", in_ready, exp_ready());
            end
            if (i == 2) begin
                checks++;
                if (in_ready !== 4'b0001) begin
                    errors++; $display("FAIL rmid_first_grant got %b want 0001", in_ready);
                end
            end
            tick();
            if (i == 1) begin
                checks++;
                if (out_valid !== 1'b0 || out_data !== '0 || out_channel !== 2'd0) begin
                    errors++; $display("FAIL rmid_cleared got v=%b d=%h c=%0d want 0/0/0", out_valid, out_data, out_channel);
                end
            end else begin
                head = exp_q[0];
                checks++;
                if (out_valid !== 1'b1 || {out_channel, out_data} !== head) begin
                    errors++; $display("FAIL rmid_data got %b/%0d/%h want 1/%0d/%h", out_valid, out_channel, out_data, head[W+1:W], head[W-1:0]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 39) == 0);
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            #1;
            checks++;
            if (in_ready !== exp_ready() || !$onehot0(in_ready)) begin
                errors++; $display("FAIL rand_ready got %b want %b", in_ready, exp_ready());
            end
            tick();
            checks++;
            if (out_valid !== (exp_q.size() != 0)) begin
                errors++; $display("FAIL rand_valid got %b want %b", out_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                checks++;
                if ({out_channel, out_data} !== head) begin
                    errors++; $display("FAIL rand_data got %0d/%h want %0d/%h", out_channel, out_data, head[W+1:W], head[W-1:0]);
                end
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_fixed_priority();
        logic [N-1:0] want;
        logic [W-1:0] want_data;
        int           want_ch;
        f_reset = 1'b1; f_in_valid = 4'hF; f_out_ready = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (f_out_valid !== 1'b0 || f_out_data !== '0) begin
            errors++; $display("FAIL fixed_reset got v=%b d=%h want 0/0", f_out_valid, f_out_data);
        end
        f_reset = 1'b0;
        for (int i = 0; i < 44; i++) begin
            f_in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            f_in_valid = (i < 4) ? 4'b1110 : 4'($urandom_range(0, 15));
            want       = f_in_valid & (~f_in_valid + 4'd1);
            want_ch    = 0;
            for (int c = N - 1; c >= 0; c--) if (f_in_valid[c]) want_ch = c;
            want_data  = chunk_of(f_in_data, want_ch);
            #1;
            checks++;
            if (f_in_ready !== want || !$onehot0(f_in_ready)) begin
                errors++; $display("FAIL fixed_ready got %b want %b", f_in_ready, want);
            end
            @(posedge clock); #1;
            checks++;
            if (f_out_valid !== (want != 0)) begin
                errors++; $display("FAIL fixed_valid got %b want %b", f_out_valid, want != 0);
            end
            if (want != 0) begin
                checks++;
                if (f_out_channel !== 2'(want_ch) || f_out_data !== want_data) begin
                    errors++; $display("FAIL fixed_data got %0d/%h want %0d/%h", f_out_channel, f_out_data, want_ch, want_data);
                end
            end
            if (i < 4) begin
                checks++;
                if (f_out_channel !== 2'd1) begin
                    errors++; $display("FAIL fixed_winner got %0d want 1", f_out_channel);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = '0; out_ready = 1'b0; in_data = '0;
        f_reset = 1'b1; f_in_valid = '0; f_out_ready = 1'b0; f_in_data = '0;
        @(posedge clock); #1;
        test_reset();
        test_round_robin();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        test_fixed_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits per channel, legal range 1..64.
REQ-002 Parameter CHANNELS, default 4: number of input channels, legal range 2..16.
REQ-003 Parameter MODE, default 0: 0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
REQ-004 Port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_data, input, CHANNELS*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port in_valid, input, CHANNELS bits: per-channel request.
REQ-008 Port in_ready, output, CHANNELS bits: per-channel accept; a transfer occurs on channel i when in_valid[i] and in_ready[i] are both high.
REQ-009 Port out_data, output, WIDTH bits: registered selected data.
REQ-010 Port out_valid, output, 1 bit: out_data holds an undelivered word.
REQ-011 Port out_ready, input, 1 bit: consumer accept.
REQ-012 Port out_channel, output, CW bits, where CW = max(1, clog2(CHANNELS)): index of the channel that supplied out_data.

Function
REQ-013 The block SHALL hold exactly one output register stage: out_data, out_channel and out_valid.
REQ-014 The load enable SHALL be (!out_valid | out_ready) & !reset.
REQ-015 At most one in_ready bit SHALL be high in any cycle.
REQ-016 in_ready[g] SHALL equal grant[g] & load_en, where grant is one-hot over the channels with in_valid high; grant SHALL be all zeros when no in_valid bit is high.
REQ-017 in_ready SHALL depend combinationally on in_valid, the priority pointer and out_ready only.
REQ-018 On a transfer from channel g, the next cycle SHALL show out_valid=1, out_data=in_data[g], out_channel=g; latency is 1 cycle.
REQ-019 When out_valid=1 and out_ready=1 with no new transfer, out_valid SHALL drop to 0 the next cycle.
REQ-020 On a simultaneous drain and load, the new word SHALL replace the old one with no bubble, sustaining 1 word per cycle.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_channel SHALL stay stable and in_ready SHALL be all zeros.
REQ-022 In MODE=0, the search SHALL begin at pointer p and proceed p, p+1, ..., wrapping modulo CHANNELS; after a transfer from channel g, p SHALL become (g+1) mod CHANNELS.
REQ-023 In MODE=0, p SHALL be unchanged in cycles with no transfer.
REQ-024 The wrap from p=CHANNELS-1 SHALL go to 0.
REQ-025 In MODE=1, the lowest-index valid channel SHALL win and the pointer SHALL be ignored (held at 0).
REQ-026 Deasserting in_valid[i] before it is granted SHALL be legal and SHALL have no side effect.
REQ-027 Unused encodings of the pointer SHALL be unreachable; p SHALL always be less than CHANNELS.

Reset
REQ-028 While reset=1 at a clock edge, the next state SHALL be: out_valid=0, out_data=0, out_channel=0, p=0.
REQ-029 in_ready SHALL be all zeros in any cycle where reset=1.
REQ-030 A word held in the output register SHALL be discarded on reset with no handshake.
REQ-031 The first grant after reset SHALL follow priority order starting from channel 0.

Structure
REQ-032 Shared package arb_pkg SHALL hold the MODE encodings (MODE_RR=0, MODE_FIXED=1) and a function computing CW from CHANNELS.
REQ-033 Sub-module rr_arbiter (parameters CHANNELS, MODE) SHALL hold the pointer register and the grant logic.
REQ-034 arb_mux SHALL hold the data selection and the output register.

Verification
REQ-035 CHANNELS=4, WIDTH=32, MODE=0, all channels valid, out_ready=1 for 8 cycles -> out_channel sequence 0,1,2,3,0,1,2,3 on consecutive cycles, out_data matching each channel's value.
REQ-036 Stall: channel 2 sends 0xDEADBEEF, then out_ready=0 for 3 cycles -> out_data stays 0xDEADBEEF, out_valid=1, in_ready=0000 throughout; releasing out_ready delivers the word once.
REQ-037 Fairness/wrap: p=3, valid=1001 -> grant channel 3 then channel 0; with valid=0001 only -> channel 0 granted on every cycle.
REQ-038 MODE=1, valid=1110 for 4 cycles -> channel 1 granted every cycle and channels 2 and 3 never granted.
REQ-039 Reset mid-operation: out_valid=1, p=2, reset pulsed for 1 cycle -> out_valid=0, out_data=0, in_ready=0 during reset; with all channels valid afterward, the first grant goes to channel 0.
REQ-040 Every test SHALL check each cycle that in_ready is one-hot or zero, and SHALL compare out_data against a reference model, raising a pass flag per check.
